// File: rtl/sc_hazard_unit.sv
// Forwarding selects and load-use stall for EX, built on a two-deep shadow of EX/MEM and MEM/WB.
// Selects and stall are combinational and ready in the same cycle; i_halt freezes the shadow state and the counter.
module sc_hazard_unit #(
  parameter int ADDR_SIZE = 5,
  parameter int CNT_SIZE  = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_halt,
  input  logic [ADDR_SIZE-1:0] i_id_rs,
  input  logic [ADDR_SIZE-1:0] i_id_rt,
  input  logic [ADDR_SIZE-1:0] i_ex_rs,
  input  logic [ADDR_SIZE-1:0] i_ex_rt,
  input  logic [ADDR_SIZE-1:0] i_ex_wb_addr,
  input  logic                 i_ex_reg_write,
  input  logic                 i_ex_mem_read,
  output logic [1:0]           o_sc_src_a,
  output logic [1:0]           o_sc_src_b,
  output logic                 o_stall,
  output logic [CNT_SIZE-1:0]  o_stall_count
);

  localparam logic [1:0] SRC_REGFILE = 2'b00;
  localparam logic [1:0] SRC_WB      = 2'b01;
  localparam logic [1:0] SRC_ALU     = 2'b10;

  logic [ADDR_SIZE-1:0] mem_addr;
  logic                 mem_rw;
  logic                 mem_mr;
  logic [ADDR_SIZE-1:0] wb_addr;
  logic                 wb_rw;
  logic [CNT_SIZE-1:0]  stall_cnt;

  logic mem_fwd_ok;
  logic wb_fwd_ok;
  logic ex_load_ok;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      mem_addr  <= '0;
      mem_rw    <= 1'b0;
      mem_mr    <= 1'b0;
      wb_addr   <= '0;
      wb_rw     <= 1'b0;
      stall_cnt <= '0;
    end else if (!i_halt) begin
      wb_addr  <= mem_addr;
      wb_rw    <= mem_rw;
      mem_addr <= i_ex_wb_addr;
      mem_rw   <= i_ex_reg_write;
      mem_mr   <= i_ex_mem_read;
      if (o_stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_SIZE'(1);
      end
    end
  end

  // r0 is hardwired zero, so a writer targeting it never forwards
  always_comb begin
    mem_fwd_ok = mem_rw && (mem_addr != '0);
    wb_fwd_ok  = wb_rw && (wb_addr != '0);

    o_sc_src_a = SRC_REGFILE;
    if (mem_fwd_ok && (mem_addr == i_ex_rs)) begin
      o_sc_src_a = SRC_ALU;
    end else if (wb_fwd_ok && (wb_addr == i_ex_rs)) begin
      o_sc_src_a = SRC_WB;
    end

    o_sc_src_b = SRC_REGFILE;
    if (mem_fwd_ok && (mem_addr == i_ex_rt)) begin
      o_sc_src_b = SRC_ALU;
    end else if (wb_fwd_ok && (wb_addr == i_ex_rt)) begin
      o_sc_src_b = SRC_WB;
    end
  end

  assign ex_load_ok    = i_ex_mem_read && i_ex_reg_write && (i_ex_wb_addr != '0);
  assign o_stall       = ex_load_ok && ((i_ex_wb_addr == i_id_rs) || (i_ex_wb_addr == i_id_rt));
  assign o_stall_count = stall_cnt;

  // A load sitting in EX/MEM has no data yet; the stall must keep its consumer out of EX.
  always_ff @(posedge i_clk) begin
    if (!i_reset && !i_halt && mem_mr && mem_fwd_ok) begin
      assert ((mem_addr != i_ex_rs) && (mem_addr != i_ex_rt));
    end
  end

endmodule

// File: tb/tb_sc_hazard_unit.sv
// Scoreboard bench for sc_hazard_unit: each row drives one cycle and queues the outputs expected for it.
module tb_sc_hazard_unit;
  localparam int AW = 5;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          halt;
  logic [AW-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_wb_addr;
  logic          ex_reg_write, ex_mem_read;
  logic [1:0]    sc_src_a, sc_src_b;
  logic          stall;
  logic [CW-1:0] stall_count;

  always #5 clk = ~clk;

  sc_hazard_unit #(.ADDR_SIZE(AW), .CNT_SIZE(CW)) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_halt         (halt),
    .i_id_rs        (id_rs),
    .i_id_rt        (id_rt),
    .i_ex_rs        (ex_rs),
    .i_ex_rt        (ex_rt),
    .i_ex_wb_addr   (ex_wb_addr),
    .i_ex_reg_write (ex_reg_write),
    .i_ex_mem_read  (ex_mem_read),
    .o_sc_src_a     (sc_src_a),
    .o_sc_src_b     (sc_src_b),
    .o_stall        (stall),
    .o_stall_count  (stall_count)
  );

  typedef struct {
    string         name;
    logic          chk;
    logic          rst;
    logic          hlt;
    logic [AW-1:0] ex_rs;
    logic [AW-1:0] ex_rt;
    logic [AW-1:0] id_rs;
    logic [AW-1:0] id_rt;
    logic [AW-1:0] wb;
    logic          rw;
    logic          mr;
    logic [1:0]    a;
    logic [1:0]    b;
    logic          stall;
    logic [CW-1:0] cnt;
  } row_t;

  typedef struct {
    string         name;
    logic [1:0]    a;
    logic [1:0]    b;
    logic          stall;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic test_reset();
    row_t rows[3];
    exp_t e;
    rows = '{
      '{"rst_hold1",   1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 16'd0},
      '{"rst_hold2",   1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 16'd0},
      '{"reset_state", 1'b1, 1'b0, 1'b0, 5'd3, 5'd4, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 16'd0}
    };
    foreach (rows[i]) begin
      @(negedge clk);
      reset = rows[i].rst; halt = rows[i].hlt;
      ex_rs = rows[i].ex_rs; ex_rt = rows[i].ex_rt; id_rs = rows[i].id_rs; id_rt = rows[i].id_rt;
      ex_wb_addr = rows[i].wb; ex_reg_write = rows[i].rw; ex_mem_read = rows[i].mr;
      if (rows[i].chk) begin
        sb.push_back('{rows[i].name, rows[i].a, rows[i].b, rows[i].stall, rows[i].cnt});
        #1;
        e = sb.pop_front();
        checks++;
        if ({sc_src_a, sc_src_b, stall, stall_count} !== {e.a, e.b, e.stall, e.cnt}) begin
          failures++;
          $display("FAIL %s: got a=%b b=%b stall=%b cnt=%h, expected a=%b b=%b stall=%b cnt=%h",
                   e.name, sc_src_a, sc_src_b, stall, stall_count, e.a, e.b, e.stall, e.cnt);
        end
      end
    end
  endtask

  task automatic test_forward();
    row_t rows[4];
    exp_t e;
    rows = '{
      '{"fwd_issue", 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 16'd0},
      '{"fwd_exmem", 1'b1, 1'b0, 1'b0, 5'd5, 5'd5, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b10, 2'b10, 1'b0, 16'd0},
      '{"fwd_memwb", 1'b1, 1'b0, 1'b0, 5'd5, 5'd5, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b01, 2'b01, 1'b0, 16'd0},
      '{"fwd_none",  1'b1, 1'b0, 1'b0, 5'd5, 5'd5, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 16'd0}
    };
    foreach (rows[i]) begin
      @(negedge clk);
      reset = rows[i].rst; halt = rows[i].hlt;
      ex_rs = rows[i].ex_rs; ex_rt = rows[i].ex_rt; id_rs = rows[i].id_rs; id_rt = rows[i].id_rt;
      ex_wb_addr = rows[i].wb; ex_reg_write = rows[i].rw; ex_mem_read = rows[i].mr;
      sb.push_back('{rows[i].name, rows[i].a, rows[i].b, rows[i].stall, rows[i].cnt});
      #1;
      e = sb.pop_front();
      checks++;
      if ({sc_src_a, sc_src_b, stall, stall_count} !== {e.a, e.b, e.stall, e.cnt}) begin
        failures++;
        $display("FAIL %s: got a=%b b=%b stall=%b cnt=%h, expected a=%b b=%b stall=%b cnt=%h",
                 e.name, sc_src_a, sc_src_b, stall, stall_count, e.a, e.b, e.stall, e.cnt);
      end
    end
  endtask

  task automatic test_back_to_back();
    row_t rows[4];
    exp_t e;
    rows = '{
      '{"b2b_first",  1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 16'd0},
      '{"b2b_second", 1'b1, 1'b0, 1'b0, 5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 2'b10, 2'b00, 1'b0, 16'd0},
      '{"b2b_prio",   1'b1, 1'b0, 1'b0, 5'd7, 5'd7, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b10, 2'b10, 1'b0, 16'd0},
      '{"b2b_split",  1'b1, 1'b0, 1'b0, 5'd7, 5'd3, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 16'd0}
    };
    foreach (rows[i]) begin
      @(negedge clk);
      reset = rows[i].rst; halt = rows[i].hlt;
      ex_rs = rows[i].ex_rs; ex_rt = rows[i].ex_rt; id_rs = rows[i].id_rs; id_rt = rows[i].id_rt;
      ex_wb_addr = rows[i].wb; ex_reg_write = rows[i].rw; ex_mem_read = rows[i].mr;
      sb.push_back('{rows[i].name, rows[i].a, rows[i].b, rows[i].stall, rows[i].cnt});
      #1;
      e = sb.pop_front();
      checks++;
      if ({sc_src_a, sc_src_b, stall, stall_count} !== {e.a, e.b, e.stall, e.cnt}) begin
        failures++;
        $display("FAIL %s: got a=%b b=%b stall=%b cnt=%h, expected a=%b b=%b stall=%b cnt=%h",
                 e.name, sc_src_a, sc_src_b, stall, stall_count, e.a, e.b, e.stall, e.cnt);
      end
    end
  endtask

  task automatic test_reg_zero();
    row_t rows[3];
    exp_t e;
    rows = '{
      '{"r0_write", 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 16'd0},
      '{"r0_load",  1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 16'd0},
      '{"r0_tail",  1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 16'd0}
    };
    foreach (rows[i]) begin
      @(negedge clk);
      reset = rows[i].rst; halt = rows[i].hlt;
      ex_rs = rows[i].ex_rs; ex_rt = rows[i].ex_rt; id_rs = rows[i].id_rs; id_rt = rows[i].id_rt;
      ex_wb_addr = rows[i].wb; ex_reg_write = rows[i].rw; ex_mem_read = rows[i].mr;
      sb.push_back('{rows[i].name, rows[i].a, rows[i].b, rows[i].stall, rows[i].cnt});
      #1;
      e = sb.pop_front();
      checks++;
      if ({sc_src_a, sc_src_b, stall, stall_count} !== {e.a, e.b, e.stall, e.cnt}) begin
        failures++;
        $display("FAIL %s: got a=%b b=%b stall=%b cnt=%h, expected a=%b b=%b stall=%b cnt=%h",
                 e.name, sc_src_a, sc_src_b, stall, stall_count, e.a, e.b, e.stall, e.cnt);
      end
    end
  endtask

  task automatic test_load_use();
    row_t rows[6];
    exp_t e;
    rows = '{
      '{"lu_stall",    1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd1,  5'd9, 5'd9,  1'b1, 1'b1, 2'b00, 2'b00, 1'b1, 16'd0},
      '{"lu_bubble",   1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd1,  5'd9, 5'd0,  1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 16'd1},
      '{"lu_resolve",  1'b1, 1'b0, 1'b0, 5'd1, 5'd9, 5'd0,  5'd0, 5'd0,  1'b0, 1'b0, 2'b00, 2'b01, 1'b0, 16'd1},
      '{"lu_rs_stall", 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd11, 5'd0, 5'd11, 1'b1, 1'b1, 2'b00, 2'b00, 1'b1, 16'd1},
      '{"lu_no_load",  1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd11, 5'd0, 5'd11, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 16'd2},
      '{"lu_no_rw",    1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd11, 5'd0, 5'd11, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 16'd2}
    };
    foreach (rows[i]) begin
      @(negedge clk);
      reset = rows[i].rst; halt = rows[i].hlt;
      ex_rs = rows[i].ex_rs; ex_rt = rows[i].ex_rt; id_rs = rows[i].id_rs; id_rt = rows[i].id_rt;
      ex_wb_addr = rows[i].wb; ex_reg_write = rows[i].rw; ex_mem_read = rows[i].mr;
      sb.push_back('{rows[i].name, rows[i].a, rows[i].b, rows[i].stall, rows[i].cnt});
      #1;
      e = sb.pop_front();
      checks++;
      if ({sc_src_a, sc_src_b, stall, stall_count} !== {e.a, e.b, e.stall, e.cnt}) begin
        failures++;
        $display("FAIL %s: got a=%b b=%b stall=%b cnt=%h, expected a=%b b=%b stall=%b cnt=%h",
                 e.name, sc_src_a, sc_src_b, stall, stall_count, e.a, e.b, e.stall, e.cnt);
      end
    end
  endtask

  task automatic test_halt();
    row_t rows[8];
    exp_t e;
    rows = '{
      '{"h_write",     1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd2, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 16'd2},
      '{"h_hold1",     1'b1, 1'b0, 1'b1, 5'd2, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0, 16'd2},
      '{"h_hold2",     1'b1, 1'b0, 1'b1, 5'd2, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0, 16'd2},
      '{"h_hold3",     1'b1, 1'b0, 1'b1, 5'd2, 5'd0, 5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 2'b10, 2'b00, 1'b1, 16'd2},
      '{"h_cnt_hold",  1'b1, 1'b0, 1'b1, 5'd2, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0, 16'd2},
      '{"h_rst",       1'b0, 1'b1, 1'b1, 5'd2, 5'd2, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 16'd0},
      '{"h_after_rst", 1'b1, 1'b0, 1'b1, 5'd2, 5'd2, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 16'd0},
      '{"h_release",   1'b1, 1'b0, 1'b0, 5'd2, 5'd2, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 16'd0}
    };
    foreach (rows[i]) begin
      @(negedge clk);
      reset = rows[i].rst; halt = rows[i].hlt;
      ex_rs = rows[i].ex_rs; ex_rt = rows[i].ex_rt; id_rs = rows[i].id_rs; id_rt = rows[i].id_rt;
      ex_wb_addr = rows[i].wb; ex_reg_write = rows[i].rw; ex_mem_read = rows[i].mr;
      if (rows[i].chk) begin
        sb.push_back('{rows[i].name, rows[i].a, rows[i].b, rows[i].stall, rows[i].cnt});
        #1;
        e = sb.pop_front();
        checks++;
        if ({sc_src_a, sc_src_b, stall, stall_count} !== {e.a, e.b, e.stall, e.cnt}) begin
          failures++;
          $display("FAIL %s: got a=%b b=%b stall=%b cnt=%h, expected a=%b b=%b stall=%b cnt=%h",
                   e.name, sc_src_a, sc_src_b, stall, stall_count, e.a, e.b, e.stall, e.cnt);
        end
      end
    end
  endtask

  // Counter starts at 0 here; before edge n it should read min(n, all-ones).
  task automatic test_saturate();
    exp_t e;
    int   n_cycles = 65540;
    for (int n = 0; n < n_cycles; n++) begin
      @(negedge clk);
      reset = 1'b0; halt = 1'b0;
      ex_rs = 5'd0; ex_rt = 5'd0; id_rs = 5'd9; id_rt = 5'd0;
      ex_wb_addr = 5'd9; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
      if (n == 0 || n == 1000 || n == 65534 || n == 65535 || n == n_cycles - 1) begin
        sb.push_back('{$sformatf("sat_n%0d", n), 2'b00, 2'b00, 1'b1,
                       (n >= 65535) ? 16'hFFFF : CW'(n)});
        #1;
        e = sb.pop_front();
        checks++;
        if ({sc_src_a, sc_src_b, stall, stall_count} !== {e.a, e.b, e.stall, e.cnt}) begin
          failures++;
          $display("FAIL %s: got a=%b b=%b stall=%b cnt=%h, expected a=%b b=%b stall=%b cnt=%h",
                   e.name, sc_src_a, sc_src_b, stall, stall_count, e.a, e.b, e.stall, e.cnt);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; halt = 1'b0;
    id_rs = '0; id_rt = '0; ex_rs = '0; ex_rt = '0;
    ex_wb_addr = '0; ex_reg_write = 1'b0; ex_mem_read = 1'b0;
    test_reset();
    test_forward();
    test_back_to_back();
    test_reg_zero();
    test_load_use();
    test_halt();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
